chip8_tick_sched: RTL and testbench

CPU/timer tick scheduler for the CHIP-8 core. It runs on the fast system clock and produces three single-cycle enables: the interpreter's instruction enable at one of four speed grades (5/10/15/20 kHz at defaults), the 60 Hz delay/sound-timer tick, and a free-running frame tick for the display. It also sequences OSD run control (pause, single-step), glitch-free speed changes, and the CHIP-8 "wait for vblank" display quirk.

---
 rtl/chip8_tick_sched_if.sv | 24 ++
 rtl/chip8_tick_sched.sv | 86 ++++++++
 tb/tb_chip8_tick_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/chip8_tick_sched_if.sv
// Control/status bundle between the CHIP-8 tick scheduler and its users.
// The master drives run control and speed requests; the slave returns enables and status.
interface chip8_tick_sched_if;
   logic [1:0] clksel;
   logic       pause;
   logic       step;
   logic       wait_vblank;
   logic       cpu_clk_en;
   logic       timer_tick;
   logic       frame_tick;
   logic       paused;
   logic       waiting;
   logic [1:0] active_sel;

   modport master (
      output clksel, pause, step, wait_vblank,
      input  cpu_clk_en, timer_tick, frame_tick, paused, waiting, active_sel
   );

   modport slave (
      input  clksel, pause, step, wait_vblank,
      output cpu_clk_en, timer_tick, frame_tick, paused, waiting, active_sel
   );
endinterface

// File: rtl/chip8_tick_sched.sv
// CHIP-8 tick scheduler: instruction enable at four speed grades, 60 Hz timer tick,
// frame tick, OSD pause/single-step, frame-aligned speed changes and vblank stall.
module chip8_tick_sched #(
   parameter int BASE_DIV  = 3000,
   parameter int FRAME_DIV = 1000000
) (
   input logic clk,
   input logic rst,
   chip8_tick_sched_if.slave bus
);

   localparam int BW = (BASE_DIV  > 1) ? $clog2(BASE_DIV)  : 1;
   localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   typedef enum logic [1:0] {ST_RUN, ST_PAUSE, ST_STEP} state_t;

   state_t        state, state_next;
   logic [BW-1:0] base_cnt;
   logic [FW-1:0] frame_cnt;
   logic [1:0]    acc, acc_next;
   logic [2:0]    sum;
   logic          bstb, fstb, fire;

   assign bstb = (base_cnt  == BW'(BASE_DIV - 1));
   assign fstb = (frame_cnt == FW'(FRAME_DIV - 1));
   assign sum  = {1'b0, acc} + {1'b0, bus.active_sel} + 3'd1;

   // sum[2] means the accumulator overflowed past 3; sum[1:0] is the carried remainder.
   always_comb begin
      state_next = state;
      acc_next   = acc;
      fire       = 1'b0;
      case (state)
         ST_RUN: begin
            if (bstb && !bus.waiting) begin
               fire     = sum[2];
               acc_next = sum[1:0];
            end
            if (bus.pause) state_next = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (!bus.pause)    state_next = ST_RUN;
            else if (bus.step) state_next = ST_STEP;
         end
         ST_STEP: begin
            // Releasing pause abandons a step that has not yet found its base tick.
            if (!bus.pause) begin
               state_next = ST_RUN;
            end else if (bstb && !bus.waiting) begin
               fire       = 1'b1;
               state_next = ST_PAUSE;
            end
         end
         default: state_next = ST_PAUSE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_PAUSE;
         base_cnt       <= '0;
         frame_cnt      <= '0;
         acc            <= 2'd0;
         bus.cpu_clk_en <= 1'b0;
         bus.timer_tick <= 1'b0;
         bus.frame_tick <= 1'b0;
         bus.paused     <= 1'b1;
         bus.waiting    <= 1'b0;
         bus.active_sel <= 2'd0;
      end else begin
         state          <= state_next;
         base_cnt       <= bstb ? '0 : base_cnt + 1'b1;
         frame_cnt      <= fstb ? '0 : frame_cnt + 1'b1;
         acc            <= acc_next;
         bus.cpu_clk_en <= fire;
         bus.timer_tick <= fstb && (state == ST_RUN);
         bus.frame_tick <= fstb;
         bus.paused     <= (state_next != ST_RUN);
         // A new request in the clearing cycle wins, stretching the stall a whole frame.
         if (bus.wait_vblank)  bus.waiting <= 1'b1;
         else if (fstb)        bus.waiting <= 1'b0;
         if (fstb || bus.paused) bus.active_sel <= bus.clksel;
      end
   end

endmodule

// File: tb/tb_chip8_tick_sched.sv
// Randomised scoreboard bench for chip8_tick_sched with a cycle-count reference model.
module tb_chip8_tick_sched;

   localparam int BASE_DIV  = 4;
   localparam int FRAME_DIV = 40;

   typedef struct packed {
      logic       en;
      logic       tmr;
      logic       frm;
      logic       psd;
      logic       wt;
      logic [1:0] sel;
   } exp_t;

   logic clk = 1'b1;
   logic rst;
   chip8_tick_sched_if bus();

   chip8_tick_sched #(.BASE_DIV(BASE_DIV), .FRAME_DIV(FRAME_DIV)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   exp_t expq[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: cycles since reset, run/step flags, rate credit, selected speed.
   int   n = 0;
   bit   m_run = 0, m_pend = 0, m_wait = 0;
   int   m_acc = 0, m_sel = 0;

   task automatic applyStimulus(input bit r, input bit [1:0] cs, input bit p,
                                input bit s, input bit wv);
      bit bstb, fstb, fire, pre_run, pre_wait;
      int tot;
      exp_t e;
      rst             = r;
      bus.clksel      = cs;
      bus.pause       = p;
      bus.step        = s;
      bus.wait_vblank = wv;
      if (r) begin
         n = 0; m_run = 0; m_pend = 0; m_wait = 0; m_acc = 0; m_sel = 0;
         e = '{en:1'b0, tmr:1'b0, frm:1'b0, psd:1'b1, wt:1'b0, sel:2'd0};
         expq.push_back(e);
         return;
      end
      bstb     = (n % BASE_DIV)  == BASE_DIV - 1;
      fstb     = (n % FRAME_DIV) == FRAME_DIV - 1;
      pre_run  = m_run;
      pre_wait = m_wait;
      fire     = 0;
      if (m_run) begin
         if (bstb && !pre_wait) begin
            tot   = m_acc + m_sel + 1;
            fire  = (tot >= 4);
            m_acc = tot % 4;
         end
         if (p) m_run = 0;
      end else if (m_pend) begin
         if (!p) begin
            m_run = 1; m_pend = 0;
         end else if (bstb && !pre_wait) begin
            fire = 1; m_pend = 0;
         end
      end else if (!p) begin
         m_run = 1;
      end else if (s) begin
         m_pend = 1;
      end
      if (fstb || !pre_run) m_sel = int'(cs);
      m_wait = wv ? 1'b1 : (fstb ? 1'b0 : pre_wait);
      e.en  = fire;
      e.tmr = fstb && pre_run;
      e.frm = fstb;
      e.psd = !m_run;
      e.wt  = m_wait;
      e.sel = 2'(m_sel);
      expq.push_back(e);
      n++;
   endtask

   task automatic checkOutput(input exp_t e);
      exp_t got;
      got = '{en:bus.cpu_clk_en, tmr:bus.timer_tick, frm:bus.frame_tick,
              psd:bus.paused, wt:bus.waiting, sel:bus.active_sel};
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("[TB] FAIL outputs at %0t: got en=%b tmr=%b frm=%b psd=%b wt=%b sel=%0d, want en=%b tmr=%b frm=%b psd=%b wt=%b sel=%0d",
                  $time, got.en, got.tmr, got.frm, got.psd, got.wt, got.sel,
                  e.en, e.tmr, e.frm, e.psd, e.wt, e.sel);
      end
   endtask

   // Monitor: every edge produces a fresh output set, so one expectation per edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard at %0t: got empty queue, want a pending expectation", $time);
         end else begin
            checkOutput(expq.pop_front());
         end
      end
   end

   initial begin
      bit [1:0] cs;
      bit       p, s, wv, r;
      int       mode, len;
      cs = 2'd3; p = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         applyStimulus(1'b1, cs, p, 1'b0, 1'b0);
      end
      for (int seg = 0; seg < 28; seg++) begin
         mode = seg % 4;
         len  = $urandom_range(60, 160);
         if (mode != 2) cs = 2'($urandom_range(0, 3));
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            r = 1'b0; s = 1'b0; wv = 1'b0;
            case (mode)
               0: p = 1'b0;
               1: begin
                  p = 1'b0;
                  if ($urandom_range(0, 29) == 0) cs = 2'($urandom_range(0, 3));
                  if ($urandom_range(0, 24) == 0) wv = 1'b1;
                  if ((n % FRAME_DIV) == FRAME_DIV - 1 && $urandom_range(0, 1) == 1) wv = 1'b1;
               end
               2: begin
                  p = ($urandom_range(0, 39) != 0);
                  s = ($urandom_range(0, 5) == 0) || (!p && $urandom_range(0, 1) == 1);
                  if ($urandom_range(0, 19) == 0) cs = 2'($urandom_range(0, 3));
                  if ($urandom_range(0, 39) == 0) wv = 1'b1;
               end
               default: begin
                  if ($urandom_range(0, 9) == 0) p = !p;
                  s  = ($urandom_range(0, 7) == 0);
                  wv = ($urandom_range(0, 19) == 0);
                  r  = ($urandom_range(0, 149) == 0);
                  if ($urandom_range(0, 14) == 0) cs = 2'($urandom_range(0, 3));
               end
            endcase
            applyStimulus(r, cs, p, s, wv);
         end
      end
      @(negedge clk);
      if (expq.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL drain: got %0d leftover expectations, want 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
